mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: MULT_CYCLES, 5, busy-cycle count for MULT/MULTU/MADD/MADDU (legal 1..15).
REQ-002 Parameter: DIV_CYCLES, 10, busy-cycle count for DIV/DIVU (legal 1..15).
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: md_start  in  1  one-cycle request qualifier for md_op.
REQ-006 Port: md_op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9-15 NONE.
REQ-007 Port: md_a  in  32  operand rs (MTHI/MTLO source).
REQ-008 Port: md_b  in  32  operand rt.
REQ-009 Port: md_busy  out  1  high while an arithmetic op is in flight.
REQ-010 Port: md_hi  out  32  architectural HI register.
REQ-011 Port: md_lo  out  32  architectural LO register.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE and BUSY, plus a 4-bit down-counter.
REQ-013 The block SHALL accept a request only in IDLE with md_start=1; requests with md_start=1 during BUSY SHALL be ignored (the pipeline stalls on md_busy).
REQ-014 On accepting MULT/MULTU/DIV/DIVU (and MADD/MADDU when enabled), the block SHALL compute the 64-bit result from md_a/md_b sampled at that edge into pending registers, enter BUSY, and load the counter with the op's cycle count.
REQ-015 md_busy SHALL be high for exactly MULT_CYCLES or DIV_CYCLES cycles, starting the cycle after the accepting edge.
REQ-016 md_hi/md_lo SHALL update from the pending registers at the edge ending the last busy cycle, simultaneously with the return to IDLE; a new request may be accepted in the following cycle.
REQ-017 MULT: {HI,LO} = signed 32x32 product; MULTU: unsigned product.
REQ-018 DIV: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend; DIVU: unsigned quotient/remainder.
REQ-019 Signed DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000.
REQ-020 Division by zero SHALL still occupy DIV_CYCLES busy cycles and leave HI and LO unchanged.
REQ-021 MTHI/MTLO accepted in IDLE SHALL write md_a to HI/LO at the accepting edge, with no busy cycles.
REQ-022 NONE opcodes with md_start=1 SHALL cause no state change.
REQ-023 md_hi/md_lo SHALL be driven directly from registers (no combinational path from inputs).

Reset
REQ-024 Asserting reset SHALL immediately force IDLE, counter=0, md_busy=0, md_hi=0, md_lo=0, pending registers=0.
REQ-025 Reset during BUSY SHALL discard the in-flight result; HI/LO remain 0 after release.
REQ-026 The first request SHALL be accepted at the first rising edge with reset low.

Configuration
REQ-027 Macro MULT_DIV_MADD_EN: when defined, MADD/MADDU SHALL compute {HI,LO} + signed/unsigned product (64-bit, wrap-around modulo 2^64) using HI/LO values at the accepting edge, with MULT_CYCLES latency.
REQ-028 Without MULT_DIV_MADD_EN, opcodes 7 and 8 SHALL be treated as NONE (no busy, no state change).

Verification
REQ-029 MULT md_a=0xFFFFFFFE(-2), md_b=3 -> busy cycles 1..5, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-030 DIV md_a=0xFFFFFFF9(-7), md_b=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 after MTHI 0x11, MTLO 0x22 -> HI=0x11, LO=0x22 after 10 busy cycles.
REQ-031 Back-to-back: MULT 2x3 accepted, md_start pulsed with MTLO 0x55 during BUSY -> ignored; LO=6 at completion; MTLO accepted the cycle after busy falls -> LO=0x55.
REQ-032 Reset asserted asynchronously in 3rd busy cycle of DIV 100/7 -> md_busy=0, HI=LO=0 immediately and remain 0 after release.
REQ-033 With MULT_DIV_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU 1x1 -> HI=0x00000001, LO=0x00000000; without it: same stimulus -> no busy, HI/LO unchanged.

Source files
------------

// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit: fixed-latency MULT/DIV with MTHI/MTLO writes.
// Define MULT_DIV_MADD_EN to enable the MADD/MADDU multiply-accumulate ops.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [3:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  output logic        md_busy,
  output logic [31:0] md_hi,
  output logic [31:0] md_lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MULT_DIV_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
`endif

  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_phi;
  logic [31:0] r_plo;
  logic        r_pwr;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_ld;
  logic [3:0]  w_cyc;
  logic [63:0] w_res;
  logic        w_res_wr;
  logic        w_mthi;
  logic        w_mtlo;
  logic        w_done;

  logic signed [63:0] w_sprod;
  logic        [63:0] w_uprod;
  logic        [31:0] w_bdiv;
  logic signed [31:0] w_squo;
  logic signed [31:0] w_srem;
  logic        [31:0] w_uquo;
  logic        [31:0] w_urem;
  logic               w_ovf;
  logic               w_bz;

  assign w_sprod = $signed(md_a) * $signed(md_b);
  assign w_uprod = {32'd0, md_a} * {32'd0, md_b};

  // Divisor forced non-zero so the dividers never see /0; result is dropped.
  assign w_bz   = (md_b == 32'd0);
  assign w_bdiv = w_bz ? 32'd1 : md_b;
  assign w_ovf  = (md_a == 32'h8000_0000) && (md_b == 32'hFFFF_FFFF);
  assign w_squo = w_ovf ? 32'sh8000_0000 : $signed(md_a) / $signed(w_bdiv);
  assign w_srem = w_ovf ? 32'sd0 : $signed(md_a) % $signed(w_bdiv);
  assign w_uquo = md_a / w_bdiv;
  assign w_urem = md_a % w_bdiv;

`ifdef MULT_DIV_MADD_EN
  logic [63:0] w_sacc;
  logic [63:0] w_uacc;
  assign w_sacc = {r_hi, r_lo} + w_sprod;
  assign w_uacc = {r_hi, r_lo} + w_uprod;
`endif

  always_comb begin
    w_next   = r_state;
    w_ld     = 1'b0;
    w_cyc    = 4'd0;
    w_res    = 64'd0;
    w_res_wr = 1'b0;
    w_mthi   = 1'b0;
    w_mtlo   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (md_start) begin
          case (md_op)
            OP_MULT: begin
              w_ld = 1'b1; w_cyc = MC;
              w_res = w_sprod; w_res_wr = 1'b1;
            end
            OP_MULTU: begin
              w_ld = 1'b1; w_cyc = MC;
              w_res = w_uprod; w_res_wr = 1'b1;
            end
            OP_DIV: begin
              w_ld = 1'b1; w_cyc = DC;
              w_res = {w_srem, w_squo}; w_res_wr = !w_bz;
            end
            OP_DIVU: begin
              w_ld = 1'b1; w_cyc = DC;
              w_res = {w_urem, w_uquo}; w_res_wr = !w_bz;
            end
            OP_MTHI: w_mthi = 1'b1;
            OP_MTLO: w_mtlo = 1'b1;
`ifdef MULT_DIV_MADD_EN
            OP_MADD: begin
              w_ld = 1'b1; w_cyc = MC;
              w_res = w_sacc; w_res_wr = 1'b1;
            end
            OP_MADDU: begin
              w_ld = 1'b1; w_cyc = MC;
              w_res = w_uacc; w_res_wr = 1'b1;
            end
`endif
            default: ;
          endcase
        end
        if (w_ld) w_next = BUSY;
      end
      BUSY: begin
        if (r_cnt == 4'd1) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_phi   <= 32'd0;
      r_plo   <= 32'd0;
      r_pwr   <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_ld) begin
        r_cnt <= w_cyc;
        r_phi <= w_res[63:32];
        r_plo <= w_res[31:0];
        r_pwr <= w_res_wr;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_done && r_pwr) begin
        r_hi <= r_phi;
        r_lo <= r_plo;
      end
      if (w_mthi) r_hi <= md_a;
      if (w_mtlo) r_lo <= md_a;
    end
  end

  assign md_busy = (r_state == BUSY);
  assign md_hi   = r_hi;
  assign md_lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed results.
// Expectations for opcodes 7/8 follow MULT_DIV_MADD_EN.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        md_start;
  logic [3:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_busy;
  logic [31:0] md_hi;
  logic [31:0] md_lo;

  int n_cmp;
  int n_err;
  int nb;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_start (md_start),
    .md_op    (md_op),
    .md_a     (md_a),
    .md_b     (md_b),
    .md_busy  (md_busy),
    .md_hi    (md_hi),
    .md_lo    (md_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    md_start = 1'b1;
    md_op    = op;
    md_a     = a;
    md_b     = b;
    tick();
    md_start = 1'b0;
    md_op    = 4'd0;
    md_a     = 32'd0;
    md_b     = 32'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (md_busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    md_start = 1'b0;
    md_op    = 4'd0;
    md_a     = 32'd0;
    md_b     = 32'd0;
    #12;
    check("rst_busy", {31'd0, md_busy}, 32'd0);
    check("rst_hi", md_hi, 32'd0);
    check("rst_lo", md_lo, 32'd0);
    reset = 1'b0;

    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    check("mult_busy1", {31'd0, md_busy}, 32'd1);
    wait_idle(nb);
    check("mult_cyc", nb, 32'd5);
    check("mult_hi", md_hi, 32'hFFFF_FFFF);
    check("mult_lo", md_lo, 32'hFFFF_FFFA);

    issue(4'd2, 32'hFFFF_FFFE, 32'd3);
    wait_idle(nb);
    check("multu_cyc", nb, 32'd5);
    check("multu_hi", md_hi, 32'h0000_0002);
    check("multu_lo", md_lo, 32'hFFFF_FFFA);

    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(nb);
    check("div_cyc", nb, 32'd10);
    check("div_hi", md_hi, 32'hFFFF_FFFF);
    check("div_lo", md_lo, 32'hFFFF_FFFD);

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(nb);
    check("divovf_hi", md_hi, 32'h0000_0000);
    check("divovf_lo", md_lo, 32'h8000_0000);

    issue(4'd5, 32'h11, 32'd0);
    check("mthi_busy", {31'd0, md_busy}, 32'd0);
    check("mthi_hi", md_hi, 32'h11);
    issue(4'd6, 32'h22, 32'd0);
    check("mtlo_lo", md_lo, 32'h22);
    issue(4'd4, 32'd7, 32'd0);
    wait_idle(nb);
    check("div0_cyc", nb, 32'd10);
    check("div0_hi", md_hi, 32'h11);
    check("div0_lo", md_lo, 32'h22);

    issue(4'd4, 32'd100, 32'd7);
    wait_idle(nb);
    check("divu_hi", md_hi, 32'd2);
    check("divu_lo", md_lo, 32'd14);

    issue(4'd0, 32'hDEAD_BEEF, 32'd1);
    check("none0_busy", {31'd0, md_busy}, 32'd0);
    issue(4'd12, 32'hDEAD_BEEF, 32'd1);
    check("none12_busy", {31'd0, md_busy}, 32'd0);
    check("none_hi", md_hi, 32'd2);
    check("none_lo", md_lo, 32'd14);

    issue(4'd1, 32'd2, 32'd3);
    issue(4'd6, 32'h55, 32'd0);
    check("b2b_ign_lo", md_lo, 32'd14);
    wait_idle(nb);
    check("b2b_cyc", nb + 1, 32'd5);
    check("b2b_lo", md_lo, 32'd6);
    check("b2b_hi", md_hi, 32'd0);
    issue(4'd6, 32'h55, 32'd0);
    check("b2b_mtlo", md_lo, 32'h55);

    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0);
    issue(4'd8, 32'd1, 32'd1);
    wait_idle(nb);
`ifdef MULT_DIV_MADD_EN
    check("maddu_cyc", nb, 32'd5);
    check("maddu_hi", md_hi, 32'h0000_0001);
    check("maddu_lo", md_lo, 32'h0000_0000);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1);
    wait_idle(nb);
    check("madd_cyc", nb, 32'd5);
    check("madd_hi", md_hi, 32'h0000_0000);
    check("madd_lo", md_lo, 32'hFFFF_FFFF);
`else
    check("maddu_cyc", nb, 32'd0);
    check("maddu_hi", md_hi, 32'h0000_0000);
    check("maddu_lo", md_lo, 32'hFFFF_FFFF);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1);
    check("madd_busy", {31'd0, md_busy}, 32'd0);
`endif

    issue(4'd5, 32'hAAAA_0000, 32'd0);
    issue(4'd6, 32'h0000_BBBB, 32'd0);
    issue(4'd3, 32'd100, 32'd7);
    tick();
    tick();
    check("rstb_busy_pre", {31'd0, md_busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rstb_busy", {31'd0, md_busy}, 32'd0);
    check("rstb_hi", md_hi, 32'd0);
    check("rstb_lo", md_lo, 32'd0);
    tick();
    #3;
    reset = 1'b0;
    repeat (12) tick();
    check("rstb_post_busy", {31'd0, md_busy}, 32'd0);
    check("rstb_post_hi", md_hi, 32'd0);
    check("rstb_post_lo", md_lo, 32'd0);

    reset = 1'b1;
    tick();
    #3;
    reset = 1'b0;
    issue(4'd6, 32'h33, 32'd0);
    check("first_edge_lo", md_lo, 32'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
